// File: rtl/i2c_target_write_receiver_if.sv
// Signal bundle between the I2C pins / byte consumer and the write receiver.
// The slave modport is the receiver's view; master is the bus + consumer side.
interface i2c_target_write_receiver_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAXIMUM_BYTES = 128
);
    localparam int COUNT_WIDTH = $clog2(MAXIMUM_BYTES + 1);

    logic                   scl_i;
    logic                   sda_i;
    logic                   sda_oen;
    logic [DATA_WIDTH-1:0]  rx_data;
    logic                   rx_valid;
    logic                   rx_first;
    logic [COUNT_WIDTH-1:0] rx_count;
    logic                   busy;
    logic                   stop_seen;
    logic                   overflow;

    modport slave (
        input  scl_i, sda_i,
        output sda_oen, rx_data, rx_valid, rx_first, rx_count, busy, stop_seen, overflow
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oen, rx_data, rx_valid, rx_first, rx_count, busy, stop_seen, overflow
    );
endinterface

// File: rtl/i2c_target_write_receiver.sv
// I2C target write-only receiver: oversamples SCL/SDA, detects START/STOP,
// matches the own address, ACKs/NACKs on SDA and strobes out data bytes.
module i2c_target_write_receiver #(
    parameter int                             SLAVE_ADDRESS_WIDTH = 7,
    parameter int                             DATA_WIDTH          = 8,
    parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS       = 7'h68,
    parameter int                             MAXIMUM_BYTES       = 128
) (
    input  logic                        pclk,
    input  logic                        presetn,
    i2c_target_write_receiver_if.slave  bus
);
    localparam int ADDR_BITS     = SLAVE_ADDRESS_WIDTH + 1;
    localparam int SHIFT_WIDTH   = (DATA_WIDTH > ADDR_BITS) ? DATA_WIDTH : ADDR_BITS;
    localparam int BIT_CNT_WIDTH = $clog2(SHIFT_WIDTH + 1);
    localparam int COUNT_WIDTH   = $clog2(MAXIMUM_BYTES + 1);
    localparam logic [BIT_CNT_WIDTH-1:0] ADDR_LAST = BIT_CNT_WIDTH'(ADDR_BITS - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] DATA_LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX = COUNT_WIDTH'(MAXIMUM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Synchronizer stages and one-cycle-delayed copies for edge detection.
    logic scl_meta_q, scl_sync_q, scl_dly_q;
    logic sda_meta_q, sda_sync_q, sda_dly_q;

    logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                     ack_phase_q, ack_phase_d;  // 1 = ACK slot in progress
    logic                     ack_q, ack_d;              // current data byte is ACKed
    logic                     first_q, first_d;          // next data byte is the first
    logic                     sda_oen_q, sda_oen_d;
    logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     rx_first_q, rx_first_d;
    logic [COUNT_WIDTH-1:0]   rx_count_q, rx_count_d;
    logic                     busy_q, busy_d;
    logic                     stop_seen_q, stop_seen_d;
    logic                     overflow_q, overflow_d;

    logic                   scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [SHIFT_WIDTH-1:0] shift_in_s;
    logic                   addr_ok_s;

    assign scl_rise_s = scl_sync_q & ~scl_dly_q;
    assign scl_fall_s = ~scl_sync_q & scl_dly_q;
    assign start_s    = sda_dly_q & ~sda_sync_q & scl_sync_q;
    assign stop_s     = ~sda_dly_q & sda_sync_q & scl_sync_q;
    assign shift_in_s = {shift_q[SHIFT_WIDTH-2:0], sda_sync_q};
    assign addr_ok_s  = (shift_in_s[ADDR_BITS-1:1] == SLAVE_ADDRESS) && (shift_in_s[0] == 1'b0);

    // Pin synchronizers; they load the idle-bus level (1) in reset.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_i;
            scl_sync_q <= scl_meta_q;
            scl_dly_q  <= scl_sync_q;
            sda_meta_q <= bus.sda_i;
            sda_sync_q <= sda_meta_q;
            sda_dly_q  <= sda_sync_q;
        end
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus START/STOP override any SCL edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (stop_s) begin
            state_d = ST_IDLE;
        end else if (start_s) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_IDLE;
                ST_ADDR: begin
                    if (scl_rise_s && (bit_cnt_q == ADDR_LAST)) begin
                        state_d = addr_ok_s ? ST_ADDR_ACK : ST_IGNORE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: state_d = (scl_fall_s && ack_phase_q) ? ST_DATA : ST_ADDR_ACK;
                ST_DATA:     state_d = (scl_rise_s && (bit_cnt_q == DATA_LAST)) ? ST_DATA_ACK : ST_DATA;
                ST_DATA_ACK: state_d = (scl_fall_s && ack_phase_q) ? ST_DATA : ST_DATA_ACK;
                ST_IGNORE:   state_d = ST_IGNORE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next-values; SDA is only changed on an SCL falling edge.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ack_phase_d = ack_phase_q;
        ack_d       = ack_q;
        first_d     = first_q;
        sda_oen_d   = sda_oen_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = rx_first_q;
        rx_count_d  = rx_count_q;
        busy_d      = busy_q;
        stop_seen_d = 1'b0;
        overflow_d  = overflow_q;
        if (stop_s) begin
            sda_oen_d   = 1'b1;
            busy_d      = 1'b0;
            stop_seen_d = 1'b1;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
        end else if (start_s) begin
            sda_oen_d   = 1'b1;
            busy_d      = 1'b1;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
            first_d     = 1'b0;
            rx_count_d  = '0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = (bit_cnt_q == ADDR_LAST) ? '0 : bit_cnt_q + BIT_CNT_WIDTH'(1);
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s && !ack_phase_q) begin
                        sda_oen_d   = 1'b0;
                        ack_phase_d = 1'b1;
                    end else if (scl_fall_s) begin
                        sda_oen_d   = 1'b1;
                        ack_phase_d = 1'b0;
                        first_d     = 1'b1;
                    end else begin
                        sda_oen_d = sda_oen_q;
                    end
                end
                ST_DATA: begin
                    if (scl_rise_s && (bit_cnt_q == DATA_LAST)) begin
                        shift_d    = shift_in_s;
                        bit_cnt_d  = '0;
                        rx_data_d  = shift_in_s[DATA_WIDTH-1:0];
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        if (rx_count_q < COUNT_MAX) begin
                            rx_count_d = rx_count_q + COUNT_WIDTH'(1);
                            ack_d      = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                            ack_d      = 1'b0;
                        end
                    end else if (scl_rise_s) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall_s && !ack_phase_q) begin
                        sda_oen_d   = ~ack_q;
                        ack_phase_d = 1'b1;
                    end else if (scl_fall_s) begin
                        sda_oen_d   = 1'b1;
                        ack_phase_d = 1'b0;
                    end else begin
                        sda_oen_d = sda_oen_q;
                    end
                end
                ST_IDLE:   sda_oen_d = 1'b1;
                ST_IGNORE: sda_oen_d = 1'b1;
                default:   sda_oen_d = 1'b1;
            endcase
        end
    end

    // Datapath and output registers; reset releases SDA on the same edge.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ack_phase_q <= 1'b0;
            ack_q       <= 1'b0;
            first_q     <= 1'b0;
            sda_oen_q   <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            rx_count_q  <= '0;
            busy_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_phase_q <= ack_phase_d;
            ack_q       <= ack_d;
            first_q     <= first_d;
            sda_oen_q   <= sda_oen_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            rx_count_q  <= rx_count_d;
            busy_q      <= busy_d;
            stop_seen_q <= stop_seen_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.sda_oen   = sda_oen_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_first  = rx_first_q;
    assign bus.rx_count  = rx_count_q;
    assign bus.busy      = busy_q;
    assign bus.stop_seen = stop_seen_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_i2c_target_write_receiver.sv
// Self-checking bench: bit-banged I2C master, open-drain SDA model, strobe scoreboard.
module tb_i2c_target_write_receiver;
    localparam int QC = 4;  // pclk cycles per quarter SCL period

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic [7:0] count;
    } ev_t;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sel_b = 1'b0;

    ev_t exp_a[$];
    ev_t obs_a[$];
    ev_t exp_b[$];
    ev_t obs_b[$];
    int  rd_a = 0;
    int  rd_b = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  stop_a = 0;
    int  oenlow_a = 0;

    i2c_target_write_receiver_if #(.DATA_WIDTH(8), .MAXIMUM_BYTES(128)) bus_a ();
    i2c_target_write_receiver_if #(.DATA_WIDTH(8), .MAXIMUM_BYTES(2))   bus_b ();

    logic sda_line_a, sda_line_b, sda_line;
    assign sda_line_a  = sda_m & bus_a.sda_oen;
    assign sda_line_b  = sda_m & bus_b.sda_oen;
    assign sda_line    = sel_b ? sda_line_b : sda_line_a;
    assign bus_a.scl_i = sel_b ? 1'b1 : scl_m;
    assign bus_a.sda_i = sel_b ? 1'b1 : sda_line_a;
    assign bus_b.scl_i = sel_b ? scl_m : 1'b1;
    assign bus_b.sda_i = sel_b ? sda_line_b : 1'b1;

    i2c_target_write_receiver #(
        .SLAVE_ADDRESS_WIDTH(7), .DATA_WIDTH(8), .SLAVE_ADDRESS(7'h68), .MAXIMUM_BYTES(128)
    ) dut_a (.pclk(pclk), .presetn(presetn), .bus(bus_a));

    i2c_target_write_receiver #(
        .SLAVE_ADDRESS_WIDTH(7), .DATA_WIDTH(8), .SLAVE_ADDRESS(7'h68), .MAXIMUM_BYTES(2)
    ) dut_b (.pclk(pclk), .presetn(presetn), .bus(bus_b));

    always #5 pclk = ~pclk;

    // Monitor: record strobes and count STOP pulses / SDA-driven cycles.
    always @(negedge pclk) begin
        if (bus_a.rx_valid === 1'b1) obs_a.push_back({bus_a.rx_data, bus_a.rx_first, bus_a.rx_count});
        if (bus_b.rx_valid === 1'b1) obs_b.push_back({bus_b.rx_data, bus_b.rx_first, 6'd0, bus_b.rx_count});
        if (bus_a.stop_seen === 1'b1) stop_a <= stop_a + 1;
        if (bus_a.sda_oen === 1'b0) oenlow_a <= oenlow_a + 1;
    end

    task automatic wait_q;
        repeat (QC) @(negedge pclk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_q;
        scl_m = 1'b1; wait_q; wait_q;
        sda_m = 1'b0; wait_q; wait_q;
        scl_m = 1'b0; wait_q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_q;
        scl_m = 1'b1; wait_q; wait_q;
        sda_m = 1'b1; wait_q; wait_q;
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        sda_m = b; wait_q;
        scl_m = 1'b1; wait_q;
        s = sda_line; wait_q;
        scl_m = 1'b0; wait_q;
    endtask

    task automatic i2c_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        repeat (4) @(negedge pclk);
        n_cmp++;
        if ({bus_a.sda_oen, bus_a.rx_data, bus_a.rx_valid, bus_a.rx_first, bus_a.rx_count,
             bus_a.busy, bus_a.stop_seen, bus_a.overflow} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_a: got oen=%b data=%h v=%b f=%b cnt=%0d busy=%b stop=%b ovf=%b, required released/zero",
                bus_a.sda_oen, bus_a.rx_data, bus_a.rx_valid, bus_a.rx_first, bus_a.rx_count, bus_a.busy, bus_a.stop_seen, bus_a.overflow);
        end
        n_cmp++;
        if ({bus_b.sda_oen, bus_b.rx_count, bus_b.busy, bus_b.overflow} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_b: got oen=%b cnt=%0d busy=%b ovf=%b, required 1/0/0/0",
                bus_b.sda_oen, bus_b.rx_count, bus_b.busy, bus_b.overflow);
        end
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_write;
        logic ack; int s0; ev_t e;
        s0 = stop_a;
        i2c_start;
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b required 1", bus_a.busy); end
        i2c_byte(8'hD0, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_addr_ack: got ack=%b required 1", ack); end
        exp_a.push_back({8'h10, 1'b1, 8'd1});
        i2c_byte(8'h10, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_data0_ack: got ack=%b required 1", ack); end
        exp_a.push_back({8'hA5, 1'b0, 8'd2});
        i2c_byte(8'hA5, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_data1_ack: got ack=%b required 1", ack); end
        i2c_stop;
        repeat (4) @(negedge pclk);
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front(); n_cmp++;
            if (rd_a >= obs_a.size()) begin n_bad++; $display("FAIL write_strobe: missing, required %h", e); end
            else begin
                if (obs_a[rd_a] !== e) begin n_bad++; $display("FAIL write_strobe: got %h required %h", obs_a[rd_a], e); end
                rd_a++;
            end
        end
        n_cmp++; if (obs_a.size() != rd_a) begin n_bad++; $display("FAIL write_extra: got %0d strobes required %0d", obs_a.size(), rd_a); end
        n_cmp++; if (bus_a.rx_count !== 8'd2) begin n_bad++; $display("FAIL write_count: got %0d required 2", bus_a.rx_count); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL write_idle: got busy=%b required 0", bus_a.busy); end
        n_cmp++; if (stop_a - s0 != 1) begin n_bad++; $display("FAIL write_stop: got %0d pulses required 1", stop_a - s0); end
    endtask

    task automatic test_mismatch;
        logic ack; int s0, o0, n0;
        s0 = stop_a; o0 = oenlow_a; n0 = obs_a.size();
        i2c_start;
        i2c_byte(8'hA0, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL mismatch_addr_ack: got ack=%b required 0", ack); end
        i2c_byte(8'h55, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL mismatch_data_ack: got ack=%b required 0", ack); end
        i2c_stop;
        repeat (4) @(negedge pclk);
        n_cmp++; if (oenlow_a != o0) begin n_bad++; $display("FAIL mismatch_sda: got %0d driven cycles required 0", oenlow_a - o0); end
        n_cmp++; if (obs_a.size() != n0) begin n_bad++; $display("FAIL mismatch_strobe: got %0d strobes required 0", obs_a.size() - n0); end
        n_cmp++; if (stop_a - s0 != 1) begin n_bad++; $display("FAIL mismatch_stop: got %0d pulses required 1", stop_a - s0); end
    endtask

    task automatic test_read;
        logic ack; int o0, n0;
        o0 = oenlow_a; n0 = obs_a.size();
        i2c_start;
        i2c_byte(8'hD1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL read_nack: got ack=%b required 0", ack); end
        i2c_byte(8'h00, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL read_ignore: got ack=%b required 0", ack); end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b required 1", bus_a.busy); end
        i2c_stop;
        repeat (4) @(negedge pclk);
        n_cmp++; if (oenlow_a != o0) begin n_bad++; $display("FAIL read_sda: got %0d driven cycles required 0", oenlow_a - o0); end
        n_cmp++; if (obs_a.size() != n0) begin n_bad++; $display("FAIL read_strobe: got %0d strobes required 0", obs_a.size() - n0); end
    endtask

    task automatic test_overflow;
        logic ack; ev_t e;
        logic [7:0] dat [3];
        logic       acks [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        acks[0] = 1'b1; acks[1] = 1'b1; acks[2] = 1'b0;
        sel_b = 1'b1;
        repeat (4) @(negedge pclk);
        i2c_start;
        i2c_byte(8'hD0, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL ovf_addr_ack: got ack=%b required 1", ack); end
        for (int i = 0; i < 3; i++) begin
            exp_b.push_back({dat[i], (i == 0), 8'((i < 2) ? i + 1 : 2)});
            n_cmp++; if (bus_b.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: byte %0d got overflow=%b required 0", i, bus_b.overflow); end
            i2c_byte(dat[i], ack);
            n_cmp++; if (ack !== acks[i]) begin n_bad++; $display("FAIL ovf_ack: byte %0d got ack=%b required %b", i, ack, acks[i]); end
        end
        n_cmp++; if (bus_b.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b required 1", bus_b.overflow); end
        n_cmp++; if (bus_b.rx_count !== 2'd2) begin n_bad++; $display("FAIL ovf_count: got %0d required 2", bus_b.rx_count); end
        i2c_stop;
        n_cmp++; if (bus_b.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b required 1", bus_b.overflow); end
        i2c_start;
        n_cmp++; if ({bus_b.overflow, bus_b.rx_count} !== {1'b0, 2'd0}) begin
            n_bad++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d required 0/0", bus_b.overflow, bus_b.rx_count);
        end
        i2c_stop;
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front(); n_cmp++;
            if (rd_b >= obs_b.size()) begin n_bad++; $display("FAIL ovf_strobe: missing, required %h", e); end
            else begin
                if (obs_b[rd_b] !== e) begin n_bad++; $display("FAIL ovf_strobe: got %h required %h", obs_b[rd_b], e); end
                rd_b++;
            end
        end
        n_cmp++; if (obs_b.size() != rd_b) begin n_bad++; $display("FAIL ovf_extra: got %0d strobes required %0d", obs_b.size(), rd_b); end
        sel_b = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_repeated_start;
        logic ack; logic s; int n0; ev_t e;
        logic [4:0] part;
        part = 5'b10110;
        i2c_start;
        i2c_byte(8'hD0, ack);
        exp_a.push_back({8'h01, 1'b1, 8'd1});
        i2c_byte(8'h01, ack);
        for (int i = 4; i >= 0; i--) i2c_bit(part[i], s);
        n0 = obs_a.size();
        i2c_start;
        n_cmp++; if (bus_a.rx_count !== 8'd0) begin n_bad++; $display("FAIL rs_count_clear: got %0d required 0", bus_a.rx_count); end
        n_cmp++; if (obs_a.size() != n0) begin n_bad++; $display("FAIL rs_partial: got %0d strobes required 0", obs_a.size() - n0); end
        i2c_byte(8'hD0, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rs_addr_ack: got ack=%b required 1", ack); end
        exp_a.push_back({8'h3C, 1'b1, 8'd1});
        i2c_byte(8'h3C, ack);
        i2c_stop;
        repeat (4) @(negedge pclk);
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front(); n_cmp++;
            if (rd_a >= obs_a.size()) begin n_bad++; $display("FAIL rs_strobe: missing, required %h", e); end
            else begin
                if (obs_a[rd_a] !== e) begin n_bad++; $display("FAIL rs_strobe: got %h required %h", obs_a[rd_a], e); end
                rd_a++;
            end
        end
        n_cmp++; if (obs_a.size() != rd_a) begin n_bad++; $display("FAIL rs_extra: got %0d strobes required %0d", obs_a.size(), rd_a); end
    endtask

    task automatic test_reset_mid_ack;
        logic ack; logic s; int n0; ev_t e;
        logic [7:0] addr;
        addr = 8'hD0;
        i2c_start;
        for (int i = 7; i >= 0; i--) i2c_bit(addr[i], s);
        n_cmp++; if (bus_a.sda_oen !== 1'b0) begin n_bad++; $display("FAIL rst_ack_driven: got oen=%b required 0", bus_a.sda_oen); end
        presetn = 1'b0;
        @(posedge pclk); #1;
        n_cmp++;
        if ({bus_a.sda_oen, bus_a.rx_data, bus_a.rx_valid, bus_a.rx_first, bus_a.rx_count,
             bus_a.busy, bus_a.stop_seen, bus_a.overflow} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rst_mid_values: got oen=%b data=%h v=%b f=%b cnt=%0d busy=%b stop=%b ovf=%b, required released/zero",
                bus_a.sda_oen, bus_a.rx_data, bus_a.rx_valid, bus_a.rx_first, bus_a.rx_count, bus_a.busy, bus_a.stop_seen, bus_a.overflow);
        end
        @(negedge pclk);
        presetn = 1'b1;
        n0 = obs_a.size();
        i2c_bit(1'b1, s);
        n_cmp++; if (s !== 1'b1) begin n_bad++; $display("FAIL rst_ack_released: got sda=%b required 1", s); end
        i2c_byte(8'h10, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ignored_ack: got ack=%b required 0", ack); end
        n_cmp++; if (obs_a.size() != n0 || bus_a.busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_ignored: got %0d strobes busy=%b required 0/0", obs_a.size() - n0, bus_a.busy);
        end
        i2c_stop;
        i2c_start;
        i2c_byte(8'hD0, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rst_fresh_ack: got ack=%b required 1", ack); end
        exp_a.push_back({8'h5A, 1'b1, 8'd1});
        i2c_byte(8'h5A, ack);
        i2c_stop;
        repeat (4) @(negedge pclk);
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front(); n_cmp++;
            if (rd_a >= obs_a.size()) begin n_bad++; $display("FAIL rst_strobe: missing, required %h", e); end
            else begin
                if (obs_a[rd_a] !== e) begin n_bad++; $display("FAIL rst_strobe: got %h required %h", obs_a[rd_a], e); end
                rd_a++;
            end
        end
        n_cmp++; if (obs_a.size() != rd_a) begin n_bad++; $display("FAIL rst_extra: got %0d strobes required %0d", obs_a.size(), rd_a); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_mismatch;
        test_read;
        test_overflow;
        test_repeated_start;
        test_reset_mid_ack;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
